// File: rtl/password_checker.sv
// BCD keypad safe controller: digit entry, answer compare, password change,
// and timed lockout after repeated failures. All outputs are registered.
module password_checker #(
  parameter int DIGIT_W     = 4,
  parameter int MAX_LEN     = 6,
  parameter int MIN_LEN     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           is_on,
  input  logic                           is_pressed,
  input  logic [DIGIT_W-1:0]             data,
  input  logic                           is_star_pressed,
  input  logic                           reset_password,
  input  logic                           clear_answer,
  output logic                           correct,
  output logic                           wrong,
  output logic                           pw_changed,
  output logic                           opened,
  output logic                           locked,
  output logic                           changing_password,
  output logic [$clog2(MAX_LEN+1)-1:0]   input_length
);
  localparam int LW = $clog2(MAX_LEN+1);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {OFF, ENTRY, CHANGE, LOCK} state_t;
  typedef logic [MAX_LEN-1:0][DIGIT_W-1:0] digits_t;

  state_t          state, state_n;
  digits_t         in_buf, in_buf_n, answer, answer_n;
  logic [LW-1:0]   input_length_n, answer_length, answer_length_n;
  logic            overflow, overflow_n;
  logic [FW-1:0]   fail_cnt, fail_cnt_n;
  logic [TW-1:0]   timer, timer_n;
  logic            correct_n, wrong_n, pw_changed_n, opened_n, locked_n;
  logic            match, digit_ok, new_pw_ok;

  // Digits past answer_length are don't-care; equal lengths make them zero anyway.
  always_comb begin
    match = (input_length == answer_length) && !overflow;
    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) < answer_length && in_buf[i] != answer[i]) match = 1'b0;
    digit_ok  = is_pressed && (data <= DIGIT_W'(9));
    new_pw_ok = !overflow && (input_length >= LW'(MIN_LEN)) &&
                (input_length <= LW'(MAX_LEN));
  end

  always_comb begin
    state_n         = state;
    in_buf_n        = in_buf;
    input_length_n  = input_length;
    overflow_n      = overflow;
    answer_n        = answer;
    answer_length_n = answer_length;
    fail_cnt_n      = fail_cnt;
    timer_n         = timer;
    opened_n        = opened;
    locked_n        = locked;
    correct_n       = 1'b0;
    wrong_n         = 1'b0;
    pw_changed_n    = 1'b0;
    case (state)
      LOCK: begin
        if (timer == '0) begin
          state_n  = is_on ? ENTRY : OFF;
          locked_n = 1'b0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: begin
        if (!is_on) begin
          state_n        = OFF;
          in_buf_n       = '0;
          input_length_n = '0;
          overflow_n     = 1'b0;
          opened_n       = 1'b0;
        end else if (state == OFF) begin
          state_n = ENTRY;
        end else if (is_star_pressed) begin
          in_buf_n       = '0;
          input_length_n = '0;
          overflow_n     = 1'b0;
          if (state == ENTRY) begin
            if (match) begin
              correct_n  = 1'b1;
              opened_n   = 1'b1;
              fail_cnt_n = '0;
            end else begin
              wrong_n  = 1'b1;
              opened_n = 1'b0;
              if (fail_cnt == FW'(MAX_FAIL-1)) begin
                state_n    = LOCK;
                locked_n   = 1'b1;
                timer_n    = TW'(LOCK_CYCLES-1);
                fail_cnt_n = '0;
              end else begin
                fail_cnt_n = fail_cnt + FW'(1);
              end
            end
          end else begin
            state_n  = ENTRY;
            opened_n = 1'b0;
            // A simultaneous factory restore wins over the new password.
            if (!clear_answer) begin
              if (new_pw_ok) begin
                answer_n        = in_buf;
                answer_length_n = input_length;
                pw_changed_n    = 1'b1;
              end else begin
                wrong_n = 1'b1;
              end
            end
          end
        end else begin
          if (digit_ok) begin
            if (input_length == LW'(MAX_LEN)) begin
              overflow_n = 1'b1;
            end else begin
              for (int i = 0; i < MAX_LEN; i++)
                if (LW'(i) == input_length) in_buf_n[i] = data;
              input_length_n = input_length + LW'(1);
            end
          end
          if (state == ENTRY && reset_password && opened) state_n = CHANGE;
        end
        if (clear_answer) begin
          answer_n        = '0;
          answer_length_n = LW'(MAX_LEN);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= OFF;
      in_buf            <= '0;
      input_length      <= '0;
      overflow          <= 1'b0;
      answer            <= '0;
      answer_length     <= LW'(MAX_LEN);
      fail_cnt          <= '0;
      timer             <= '0;
      correct           <= 1'b0;
      wrong             <= 1'b0;
      pw_changed        <= 1'b0;
      opened            <= 1'b0;
      locked            <= 1'b0;
      changing_password <= 1'b0;
    end else begin
      state             <= state_n;
      in_buf            <= in_buf_n;
      input_length      <= input_length_n;
      overflow          <= overflow_n;
      answer            <= answer_n;
      answer_length     <= answer_length_n;
      fail_cnt          <= fail_cnt_n;
      timer             <= timer_n;
      correct           <= correct_n;
      wrong             <= wrong_n;
      pw_changed        <= pw_changed_n;
      opened            <= opened_n;
      locked            <= locked_n;
      changing_password <= (state_n == CHANGE);
    end
  end
endmodule

// File: tb/tb_password_checker.sv
// Bench for password_checker: directed table, corner sequences, and random
// traffic compared against a queue-based behavioural model.
module tb_password_checker;
  localparam int MAX_LEN = 6, MIN_LEN = 4, MAX_FAIL = 3, LOCK_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset, is_on, is_pressed, is_star_pressed, reset_password, clear_answer;
  logic [3:0] data;
  logic       correct, wrong, pw_changed, opened, locked, changing_password;
  logic [2:0] input_length;

  always #5 clk = ~clk;

  password_checker #(.DIGIT_W(4), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN),
                     .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .reset(reset), .is_on(is_on), .is_pressed(is_pressed), .data(data),
    .is_star_pressed(is_star_pressed), .reset_password(reset_password),
    .clear_answer(clear_answer), .correct(correct), .wrong(wrong),
    .pw_changed(pw_changed), .opened(opened), .locked(locked),
    .changing_password(changing_password), .input_length(input_length));

  typedef struct {
    bit rst, on, pr; bit [3:0] d; bit st, rp, ca;
  } in_t;
  typedef struct {
    in_t i; bit c, w, p, o; int len;
  } vec_t;

  int n_cmp = 0, n_bad = 0;

  // Behavioural model: mode 0 off, 1 entry, 2 change, 3 lock.
  int md, fails, lock_left;
  int ent[$], ans[$];
  bit ovf, m_c, m_w, m_p, m_o;

  function automatic void set_factory();
    ans.delete();
    for (int k = 0; k < MAX_LEN; k++) ans.push_back(0);
  endfunction

  function automatic bit m_match();
    if (ovf || ent.size() != ans.size()) return 1'b0;
    foreach (ent[k]) if (ent[k] != ans[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(in_t x);
    m_c = 0; m_w = 0; m_p = 0;
    if (x.rst) begin
      md = 0; ent.delete(); ovf = 0; set_factory(); fails = 0; lock_left = 0; m_o = 0;
      return;
    end
    if (md == 3) begin
      lock_left--;
      if (lock_left == 0) md = x.on ? 1 : 0;
      return;
    end
    if (!x.on) begin
      md = 0; ent.delete(); ovf = 0; m_o = 0;
    end else if (md == 0) begin
      md = 1;
    end else if (x.st) begin
      if (md == 1) begin
        if (m_match()) begin m_c = 1; m_o = 1; fails = 0; end
        else begin
          m_w = 1; m_o = 0; fails++;
          if (fails == MAX_FAIL) begin md = 3; lock_left = LOCK_CYCLES; fails = 0; end
        end
      end else begin
        md = 1; m_o = 0;
        if (!x.ca) begin
          if (!ovf && ent.size() >= MIN_LEN) begin ans = ent; m_p = 1; end
          else m_w = 1;
        end
      end
      ent.delete(); ovf = 0;
    end else begin
      if (x.pr && x.d <= 9) begin
        if (ent.size() == MAX_LEN) ovf = 1;
        else ent.push_back(int'(x.d));
      end
      if (md == 1 && x.rp && m_o) md = 2;
    end
    if (x.ca) set_factory();
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_c, m_w, m_p, m_o, md == 3, md == 2, 3'(ent.size())};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {correct, wrong, pw_changed, opened, locked, changing_password, input_length};
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(in_t x, string tag);
    reset = x.rst; is_on = x.on; is_pressed = x.pr; data = x.d;
    is_star_pressed = x.st; reset_password = x.rp; clear_answer = x.ca;
    @(posedge clk);
    model_step(x);
    #1;
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL model_%s: got %h, expected %h (c w p o l chg len)", tag, dut_vec(), model_vec());
    end
  endtask

  function automatic in_t mk(bit rst, bit on, bit pr, bit [3:0] d, bit st, bit rp, bit ca);
    in_t x;
    x.rst = rst; x.on = on; x.pr = pr; x.d = d; x.st = st; x.rp = rp; x.ca = ca;
    return x;
  endfunction
  function automatic in_t dg(int d); return mk(0, 1, 1, 4'(d), 0, 0, 0); endfunction
  function automatic in_t sr();      return mk(0, 1, 0, 0, 1, 0, 0); endfunction
  function automatic in_t idl();     return mk(0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic in_t rpw();     return mk(0, 1, 0, 0, 0, 1, 0); endfunction

  vec_t tbl[$];
  function automatic void add(in_t i, bit c, bit w, bit p, bit o, int len);
    vec_t v;
    v.i = i; v.c = c; v.w = w; v.p = p; v.o = o; v.len = len;
    tbl.push_back(v);
  endfunction

  task automatic enter(int d[$], string tag);
    foreach (d[k]) apply(dg(d[k]), tag);
    apply(sr(), tag);
  endtask

  initial begin
    // Default password, change, mismatch of old one, rejected short password.
    add(idl(), 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) add(dg(0), 0, 0, 0, 0, k);
    add(sr(), 1, 0, 0, 1, 0);
    add(idl(), 0, 0, 0, 1, 0);
    add(rpw(), 0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) add(dg(k), 0, 0, 0, 1, k);
    add(sr(), 0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) add(dg(k), 0, 0, 0, 0, k);
    add(sr(), 1, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) add(dg(0), 0, 0, 0, 1, k);
    add(sr(), 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(dg(k), 0, 0, 0, 0, k);
    add(sr(), 1, 0, 0, 1, 0);
    add(rpw(), 0, 0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) add(dg(5), 0, 0, 0, 1, k);
    add(sr(), 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(dg(k), 0, 0, 0, 0, k);
    add(sr(), 1, 0, 0, 1, 0);

    apply(mk(1, 0, 0, 0, 0, 0, 0), "reset");
    apply(mk(1, 1, 1, 3, 1, 1, 1), "reset");
    check("reset_outputs", int'(dut_vec()), 0);

    foreach (tbl[k]) begin
      apply(tbl[k].i, "table");
      check($sformatf("table[%0d]", k),
            int'({correct, wrong, pw_changed, opened, input_length}),
            int'({tbl[k].c, tbl[k].w, tbl[k].p, tbl[k].o, 3'(tbl[k].len)}));
    end
    check("after_short_reject_not_changing", int'(changing_password), 0);

    // Lockout: three failures, eight ignored cycles, then back to ENTRY.
    for (int k = 0; k < 3; k++) begin
      apply(dg(9), "lock");
      apply(sr(), "lock");
      check("lock_wrong", int'(wrong), 1);
    end
    check("locked_after_3rd", int'(locked), 1);
    for (int k = 1; k < LOCK_CYCLES; k++) begin
      apply(dg(1), "lock");
      check("lock_hold", int'({locked, input_length}), int'({1'b1, 3'd0}));
    end
    apply(dg(1), "lock");
    check("lock_exit", int'({locked, changing_password, input_length}), 0);
    apply(dg(1), "lock");
    check("post_lock_digit", int'(input_length), 1);
    apply(sr(), "lock");

    // Overflow, then collision of star and digit.
    for (int k = 0; k < 7; k++) apply(dg(0), "ovf");
    check("ovf_len_capped", int'(input_length), MAX_LEN);
    apply(sr(), "ovf");
    check("ovf_wrong", int'({wrong, input_length}), int'({1'b1, 3'd0}));
    enter('{1, 2, 3, 4}, "ovf");
    check("ovf_recover", int'(correct), 1);
    apply(dg(5), "coll");
    apply(mk(0, 1, 1, 7, 1, 0, 0), "coll");
    check("coll_len", int'({wrong, input_length}), int'({1'b1, 3'd0}));
    enter('{1, 2, 3, 4}, "coll");
    check("coll_digit_dropped", int'(correct), 1);

    // clear_answer beats a simultaneous star in CHANGE.
    apply(rpw(), "clr");
    for (int k = 0; k < 4; k++) apply(dg(8), "clr");
    apply(mk(0, 1, 0, 0, 1, 0, 1), "clr");
    check("clr_no_pwc", int'({pw_changed, wrong, changing_password}), 0);
    enter('{8, 8, 8, 8}, "clr");
    check("clr_new_rejected", int'(wrong), 1);
    enter('{0, 0, 0, 0, 0, 0}, "clr");
    check("clr_factory", int'(correct), 1);

    // Reset in the middle of a lockout.
    enter('{8, 8, 8, 8}, "rlk");
    enter('{2, 2, 2, 2}, "rlk");
    enter('{4}, "rlk");
    apply(idl(), "rlk");
    check("rlk_locked", int'(locked), 1);
    apply(mk(1, 1, 0, 0, 0, 0, 0), "rlk");
    check("rlk_cleared", int'(dut_vec()), 0);
    apply(dg(3), "rlk");
    check("rlk_off_ignores_digit", int'(input_length), 0);
    enter('{0, 0, 0, 0, 0, 0}, "rlk");
    check("rlk_factory", int'(correct), 1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      in_t x;
      x.rst = ($urandom_range(0, 299) == 0);
      x.on  = ($urandom_range(0, 49) != 0);
      x.pr  = ($urandom_range(0, 3) != 0);
      x.d   = ($urandom_range(0, 9) < 7) ? 4'd0 : 4'($urandom_range(0, 15));
      x.st  = ($urandom_range(0, 6) == 0);
      x.rp  = ($urandom_range(0, 4) == 0);
      x.ca  = ($urandom_range(0, 99) == 0);
      apply(x, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
